// File: rtl/ddfs_pkg.sv
// Shared constants and FSM state type for the DDFS frequency meter.
package ddfs_pkg;

    localparam int unsigned FCW_W    = 23;
    localparam int unsigned MIDSCALE = 128;

    typedef enum logic [1:0] {
        StSeek,
        StMeas,
        StDiv
    } state_e;

endpackage

// File: rtl/freq_div.sv
// Serial restoring divider: one quotient bit per cycle, FCW_W iterations.
// The numerator is 2*dividend, so a power-of-two numerator of DIVD_W+1 bits
// fits the DIVD_W-bit port. The caller must guarantee
// (2*dividend >> FCW_W) < divisor so the quotient fits FCW_W bits.
module freq_div import ddfs_pkg::*; #(
    parameter int unsigned DIVD_W = 27,
    parameter int unsigned DIVS_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIVD_W-1:0] dividend,
    input  logic [DIVS_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [FCW_W-1:0]  quotient
);

    localparam logic [4:0] ITERS = 5'(FCW_W);

    logic [DIVS_W-1:0] rem_q, rem_d;
    logic [DIVS_W-1:0] dvs_q, dvs_d;
    logic [FCW_W-1:0]  quo_q, quo_d;
    logic [FCW_W-1:0]  shf_q, shf_d;
    logic [4:0]        iter_q, iter_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DIVS_W:0]   trial;
    logic [DIVS_W:0]   diff;
    logic              fits;

    assign trial = {rem_q, shf_q[FCW_W-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign fits  = trial >= {1'b0, dvs_q};

    // Next-state: load on start, one shift/subtract step per busy cycle.
    always_comb begin
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        shf_d  = shf_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            // Upper numerator bits form the initial partial remainder.
            rem_d  = DIVS_W'(dividend[DIVD_W-1:FCW_W-1]);
            shf_d  = {dividend[FCW_W-2:0], 1'b0};
            dvs_d  = divisor;
            quo_d  = '0;
            iter_d = ITERS;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = fits ? diff[DIVS_W-1:0] : trial[DIVS_W-1:0];
            quo_d  = {quo_q[FCW_W-2:0], fits};
            shf_d  = {shf_q[FCW_W-2:0], 1'b0};
            iter_d = iter_q - 5'd1;
            if (iter_q == 5'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            shf_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            shf_q  <= shf_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/ddfs_freq_meter.sv
// Estimates a DDFS frequency control word from its sine output by timing
// 2^NPER_LOG2 hysteretic midscale crossings and dividing 2^(23+NPER_LOG2)
// by the cycle count.
module ddfs_freq_meter import ddfs_pkg::*; #(
    parameter int unsigned HYST      = 8,
    parameter int unsigned NPER_LOG2 = 4,
    parameter int unsigned CNT_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       samp,
    output logic [FCW_W-1:0] fcontrol_est,
    output logic             valid,
    output logic             no_sig
);

    localparam int unsigned     DIVD_W   = FCW_W + NPER_LOG2;
    localparam logic [7:0]      ARM_TH   = 8'(MIDSCALE - HYST);
    localparam logic [7:0]      CROSS_TH = 8'(MIDSCALE + HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NPER_C  = CNT_W'(1) << NPER_LOG2;
    // Half of 2^(23+NPER_LOG2); the divider doubles it back.
    localparam logic [DIVD_W-1:0] DIVIDEND = DIVD_W'(1) << (DIVD_W - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NPER_LOG2-1:0] ncross_q, ncross_d;
    logic                 armed_q, armed_d;
    logic [FCW_W-1:0]     est_q, est_d;
    logic                 valid_q, valid_d;
    logic                 no_sig_q, no_sig_d;

    logic                 crossing, counting, timeout, win_end, sat;
    logic                 div_start, div_abort, div_busy, div_done;
    logic [FCW_W-1:0]     div_quo;

    assign crossing = armed_q && (samp >= CROSS_TH);
    assign counting = (state_q != StSeek);
    assign timeout  = counting && (cnt_q == CNT_MAX);
    assign win_end  = counting && crossing && (&ncross_q) && !timeout;
    assign sat      = (cnt_q <= NPER_C);

    // Arm below the low threshold; a crossing disarms in the same cycle.
    always_comb begin
        armed_d = armed_q;
        if (crossing) begin
            armed_d = 1'b0;
        end else if (samp < ARM_TH) begin
            armed_d = 1'b1;
        end
    end

    // FSM next-state, counters and output updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ncross_d  = ncross_q;
        est_d     = est_q;
        valid_d   = 1'b0;
        no_sig_d  = no_sig_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        unique case (state_q)
            StSeek: begin
                if (crossing) begin
                    state_d  = StMeas;
                    cnt_d    = CNT_W'(1);
                    ncross_d = '0;
                end
            end
            StMeas, StDiv: begin
                cnt_d = cnt_q + 1'b1;
                if (crossing) begin
                    ncross_d = ncross_q + 1'b1;
                end
                // Windows are back-to-back: the ending crossing opens the next.
                if (win_end) begin
                    cnt_d = CNT_W'(1);
                end
                if (state_q == StMeas && win_end) begin
                    if (sat) begin
                        est_d    = '1;
                        valid_d  = 1'b1;
                        no_sig_d = 1'b0;
                    end else if (!div_busy) begin
                        div_start = 1'b1;
                        state_d   = StDiv;
                    end
                end
                if (state_q == StDiv && div_done) begin
                    est_d    = div_quo;
                    valid_d  = 1'b1;
                    no_sig_d = 1'b0;
                    state_d  = StMeas;
                end
                // Timeout overrides everything, including a same-cycle crossing.
                if (timeout) begin
                    state_d   = StSeek;
                    cnt_d     = '0;
                    ncross_d  = '0;
                    est_d     = '0;
                    valid_d   = 1'b0;
                    no_sig_d  = 1'b1;
                    div_start = 1'b0;
                    div_abort = 1'b1;
                end
            end
            default: state_d = StSeek;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StSeek;
            cnt_q    <= '0;
            ncross_q <= '0;
            armed_q  <= 1'b0;
            est_q    <= '0;
            valid_q  <= 1'b0;
            no_sig_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ncross_q <= ncross_d;
            armed_q  <= armed_d;
            est_q    <= est_d;
            valid_q  <= valid_d;
            no_sig_q <= no_sig_d;
        end
    end

    freq_div #(
        .DIVD_W (DIVD_W),
        .DIVS_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (DIVIDEND),
        .divisor  (cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign fcontrol_est = est_q;
    assign valid        = valid_q;
    assign no_sig       = no_sig_q;

endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Directed bench for ddfs_freq_meter: default instance plus a CNT_W=16 one.
module tb_ddfs_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  samp;
    logic [22:0] est, est16;
    logic        valid, valid16;
    logic        no_sig, no_sig16;

    int checks;
    int failures;
    int cyc = 0;

    logic [22:0] phase;
    logic        seen, sig_low;
    int          nv, first_v, second_v, t1, t2, last16, rise;
    logic [22:0] v1, v2;

    ddfs_freq_meter dut (
        .clk          (clk),
        .rst          (rst),
        .samp         (samp),
        .fcontrol_est (est),
        .valid        (valid),
        .no_sig       (no_sig)
    );

    ddfs_freq_meter #(.CNT_W(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .samp         (samp),
        .fcontrol_est (est16),
        .valid        (valid16),
        .no_sig       (no_sig16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] got,
                               input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    function automatic logic [7:0] sine_val(input logic [22:0] ph, input real amp);
        real a;
        int  v;
        a = 6.283185307179586 * real'(ph) / 8388608.0;
        v = 128 + $rtoi($floor(amp * $sin(a) + 0.5));
        return 8'(v);
    endfunction

    // Leaves the bench just after an edge with reset released.
    task automatic restart();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        samp     = 8'd128;
        phase    = '0;
        repeat (3) tick();
        check("reset_valid", 32'(valid), 0);
        check("reset_est", 32'(est), 0);
        check("reset_no_sig", 32'(no_sig), 1);
        check("reset_est16", 32'(est16), 0);

        // Small sine inside the hysteresis band never arms.
        rst     = 1'b0;
        seen    = 1'b0;
        sig_low = 1'b0;
        for (int i = 0; i < 600; i++) begin
            phase += 23'h010000;
            samp = sine_val(phase, 6.0);
            tick();
            if (valid || valid16) seen = 1'b1;
            if (!no_sig) sig_low = 1'b1;
        end
        check("hyst_no_valid", 32'(seen), 0);
        check("hyst_no_sig_held", 32'(sig_low), 0);

        // Period-2 toggle; window ends at edge 34, reset at edge 44.
        restart();
        samp = 8'd0;
        seen = 1'b0;
        for (int i = 1; i <= 44; i++) begin
            tick();
            if (valid) seen = 1'b1;
            samp = (i % 2 == 1) ? 8'd255 : 8'd0;
        end
        rst = 1'b1;
        tick();
        check("middiv_valid", 32'(valid), 0);
        check("middiv_est", 32'(est), 0);
        check("middiv_no_sig", 32'(no_sig), 1);
        for (int i = 0; i < 30; i++) begin
            samp = (i % 2 == 1) ? 8'd255 : 8'd0;
            tick();
            if (valid) seen = 1'b1;
        end
        check("middiv_no_pulse", 32'(seen), 0);

        // Full toggle run: C=32, valids at edges 58 and 90.
        restart();
        samp     = 8'd0;
        nv       = 0;
        first_v  = 0;
        second_v = 0;
        v1       = '0;
        v2       = '0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (valid) begin
                nv++;
                if (nv == 1) begin
                    first_v = i;
                    v1      = est;
                end else if (nv == 2) begin
                    second_v = i;
                    v2       = est;
                end
            end
            samp = (i % 2 == 1) ? 8'd255 : 8'd0;
        end
        check("toggle_first_edge", 32'(first_v), 58);
        check("toggle_second_edge", 32'(second_v), 90);
        check("toggle_est1", 32'(v1), 32'h400000);
        check("toggle_est2", 32'(v2), 32'h400000);
        check("toggle_count", 32'(nv), 2);
        check("toggle_no_sig", 32'(no_sig), 0);

        // Exact 128-cycle period.
        restart();
        phase  = '0;
        samp   = sine_val(phase, 127.0);
        nv     = 0;
        t1     = 0;
        t2     = 0;
        last16 = 0;
        for (int i = 1; i <= 4500; i++) begin
            tick();
            if (valid) begin
                nv++;
                check("sine128_est", 32'(est), 32'h010000);
                if (nv == 1) t1 = cyc;
                else t2 = cyc;
            end
            if (valid16) last16 = cyc;
            phase += 23'h010000;
            samp = sine_val(phase, 127.0);
        end
        check("sine128_count", 32'(nv), 2);
        check("sine128_spacing", 32'(t2 - t1), 2048);
        check("sine128_no_sig", 32'(no_sig), 0);
        check("sine128_est16", 32'(est16), 32'h010000);

        // Flat input: CNT_W=16 instance times out 65535 cycles after window start.
        samp = 8'd128;
        rise = 0;
        seen = 1'b0;
        for (int i = 0; i < 66000 && rise == 0; i++) begin
            tick();
            if (valid16) seen = 1'b1;
            if (no_sig16) rise = cyc;
        end
        check("timeout_detected", 32'(rise != 0), 1);
        check("timeout_cycles", 32'(rise - last16), 65535 - 24);
        check("timeout_est16", 32'(est16), 0);
        check("timeout_no_valid", 32'(seen), 0);
        check("timeout_wide_no_sig", 32'(no_sig), 0);

        // Non-integer period 146.29 cycles.
        restart();
        phase = '0;
        samp  = sine_val(phase, 127.0);
        nv    = 0;
        for (int i = 1; i <= 5400; i++) begin
            tick();
            if (valid) begin
                nv++;
                check_range("sine_e000_est", 32'(est), 57312, 57376);
            end
            phase += 23'h00E000;
            samp = sine_val(phase, 127.0);
        end
        check("sine_e000_count", 32'(nv >= 2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddfs_freq_meter.md
DDFS_FREQ_METER -- requirements
Module: ddfs_freq_meter

Interface
REQ-001 SHALL have parameter HYST, default 8: hysteresis in LSBs around midscale 128; legal range 1..64.
REQ-002 SHALL have parameter NPER_LOG2, default 4: averaging window is 2^NPER_LOG2 periods; legal range 4..8.
REQ-003 SHALL have parameter CNT_W, default 24: width of the window cycle counter; legal range 16..28.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 samp  input  8  offset-binary sine sample (DDFS output format), midscale 128, sampled every clk.
REQ-007 fcontrol_est  output  23  estimated DDFS frequency control word, held between updates.
REQ-008 valid  output  1  one-cycle pulse when fcontrol_est updates.
REQ-009 no_sig  output  1  high while no signal is detected; cleared by the next valid.

Function
REQ-010 Arming: armed SHALL set when samp < 128-HYST.
REQ-011 Crossing event: in any cycle where armed=1 and samp >= 128+HYST, a crossing SHALL be registered and armed SHALL clear in that cycle.
REQ-012 FSM states: SEEK (wait for first crossing), MEAS (count), DIV (serial divide).
REQ-013 SEEK->MEAS on a crossing; the cycle counter C SHALL load 1 and the crossing counter SHALL load 0.
REQ-014 In MEAS, C SHALL increment every cycle, and every crossing SHALL increment the crossing count.
REQ-015 Window end: the 2^NPER_LOG2-th crossing in MEAS SHALL latch the C value including that cycle, giving the cycles for 2^NPER_LOG2 periods.
REQ-016 At the same edge, C SHALL restart at 1 for the next window, so windows are back-to-back.
REQ-017 Estimate SHALL equal floor(2^(23+NPER_LOG2) / C), computed by the sub-module.
REQ-018 If C <= 2^NPER_LOG2, the result SHALL saturate to 23'h7FFFFF without dividing; valid SHALL pulse on the cycle after the window end.
REQ-019 Otherwise, restoring division SHALL take exactly 23 iterations; valid SHALL pulse 24 cycles after the window-end edge.
REQ-020 Measurement SHALL continue during DIV. A window lasts at least 32 cycles, so it cannot end before the divide completes (NPER_LOG2 >= 4 guarantees this).
REQ-021 Timeout: if C reaches 2^CNT_W-1 in MEAS, the FSM SHALL go to SEEK with no_sig=1 and fcontrol_est=0; any pending divide SHALL be abandoned with no valid.
REQ-022 If a crossing and a timeout occur in the same cycle, the timeout SHALL win.
REQ-023 Minimum detectable period is 2 cycles; faster inputs SHALL be unspecified but bounded by saturation.

Reset
REQ-024 Asserting rst SHALL set the following, including mid-divide: fcontrol_est=0, valid=0, no_sig=1, armed=0, counters=0, FSM=SEEK.
REQ-025 After rst deasserts, the first valid SHALL require a full window after the first crossing.

Structure
REQ-026 A package ddfs_pkg SHALL hold FCW_W=23, MIDSCALE=128, and the FSM state enum.
REQ-027 A single sub-module freq_div SHALL implement the serial restoring divider.
REQ-028 freq_div SHALL have start/busy/done handshake, dividend 23+NPER_LOG2 bits, divisor CNT_W bits, and a 23-bit quotient.
REQ-029 Crossing detection, counters and FSM SHALL stay in the top module, within 120-400 lines of RTL total.

Verification
REQ-030 Period test: ideal 8-bit sine with period exactly 128 cycles (DDFS fcontrol=23'h010000), defaults -> after settling, fcontrol_est=23'h010000 exactly, valid every 2048 cycles.
REQ-031 Non-integer period: DDFS fcontrol=23'h00E000 (period 146.29) -> fcontrol_est within 57344±32 on every valid.
REQ-032 Fastest input: samp toggles 0/255 every cycle -> C=32, fcontrol_est=23'h400000; a 1-cycle-period stimulus is not reachable under REQ-011.
REQ-033 Timeout: CNT_W=16, samp held at 128 after one valid -> no_sig rises and fcontrol_est=0 exactly 65535 cycles after the last window start; no valid during that interval.
REQ-034 Hysteresis: sine ±6 LSB around 128 with HYST=8 -> never valid, no_sig stays 1.
REQ-035 Reset mid-divide: assert rst 10 cycles after a window end -> no valid pulse, outputs at reset values, correct estimate after re-lock.
